// File: rtl/shift_register_taps_pkg.sv
// Shared definitions for the tapped shift register.
//  - sr_state_e : 2-bit FSM state encoding (IDLE / FILL / FULL / DRAIN)
//  - tap_lsb()  : bit offset of tap k inside the flattened tap vector
// Optional feature macro: SR_TAPS_TRAIL_PAD_EN (enables the zero-pad DRAIN state).
package shift_register_taps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } sr_state_e;

  // Tap k occupies taps[tap_lsb(k, WIDTH) +: WIDTH]; tap0 is the newest sample.
  function automatic int tap_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/shift_register_taps_if.sv
// Bus interface of the tapped shift register.
//  master : producer side (drives clear, shift_in, inp_sr, drain; observes the rest)
//  slave  : the shift register itself
// Signals:
//  clear         sync clear request
//  shift_in      input valid, accepted when shift_in && in_ready
//  inp_sr        input sample (WIDTH bits)
//  drain         single-cycle zero-pad drain request
//  in_ready      low while draining
//  taps          DEPTH*WIDTH flattened taps, tap0 at the LSBs
//  fill_cnt      number of real samples held
//  window_valid  one-cycle pulse: taps hold a window
//  drain_done    one-cycle pulse: drain finished
interface shift_register_taps_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   clear;
  logic                   shift_in;
  logic [WIDTH-1:0]       inp_sr;
  logic                   drain;
  logic                   in_ready;
  logic [DEPTH*WIDTH-1:0] taps;
  logic [CNT_W-1:0]       fill_cnt;
  logic                   window_valid;
  logic                   drain_done;

  modport master (
    output clear, shift_in, inp_sr, drain,
    input  in_ready, taps, fill_cnt, window_valid, drain_done
  );

  modport slave (
    input  clear, shift_in, inp_sr, drain,
    output in_ready, taps, fill_cnt, window_valid, drain_done
  );

endinterface

// File: rtl/shift_register_taps_sr_tap_stage.sv
// One WIDTH-bit tap register with enable and load value.
// Ports:
//  clk       clock (rising edge)
//  rst       asynchronous active-high reset, clears the tap to 0
//  en        load enable
//  load_val  value captured when en is high
//  q         registered tap value
module sr_tap_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] tap_d;
  logic [WIDTH-1:0] tap_q;

  // Next tap value: load when enabled, otherwise hold.
  always_comb begin
    tap_d = tap_q;
    if (en) begin
      tap_d = load_val;
    end else begin
      tap_d = tap_q;
    end
  end

  // Tap storage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_q <= {WIDTH{1'b0}};
    end else begin
      tap_q <= tap_d;
    end
  end

  assign q = tap_q;

endmodule

// File: rtl/shift_register_taps.sv
// Parametrised tapped shift register feeding the convolver window datapath.
// Holds DEPTH taps (tap0 newest), tracks how many real samples are held,
// strobes window_valid whenever a full window is present after a shift,
// supports synchronous clear and input back-pressure.
// Optional macro SR_TAPS_TRAIL_PAD_EN: a drain request shifts zeros in at
// row end, emitting trailing padded windows, then pulses drain_done.
// Without the macro the DRAIN state is unreachable, drain is ignored,
// in_ready is constant 1 and drain_done stays 0.
// Ports:
//  clk   clock, all state on rising edge
//  rst   asynchronous active-high reset
//  bus   shift_register_taps_if.slave (clear, shift_in, inp_sr, drain,
//        in_ready, taps, fill_cnt, window_valid, drain_done)
module shift_register_taps
  import shift_register_taps_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_register_taps_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sr_state_e        state_d, state_q;
  logic [CNT_W-1:0] fill_cnt_d, fill_cnt_q;
  logic             window_valid_d, window_valid_q;
  logic             drain_done_d, drain_done_q;

  logic             in_ready_s;
  logic             accept_s;
  logic             shift_s;     // move every tap one position toward the oldest end
  logic             pad_s;       // shift a zero into tap0 instead of inp_sr
  logic             tap_en_s;

  logic [WIDTH-1:0] tap_ld_s  [DEPTH];
  logic [WIDTH-1:0] tap_val_s [DEPTH];

`ifdef SR_TAPS_TRAIL_PAD_EN
  assign in_ready_s = (state_q != ST_DRAIN);
`else
  logic unused_drain;
  assign unused_drain = bus.drain;
  assign in_ready_s   = 1'b1;
`endif

  assign accept_s = bus.shift_in && in_ready_s;

  // Next-state, fill counter and pulse logic; priority clear > drain > shift.
  always_comb begin
    state_d        = state_q;
    fill_cnt_d     = fill_cnt_q;
    window_valid_d = 1'b0;
    drain_done_d   = 1'b0;
    shift_s        = 1'b0;
    pad_s          = 1'b0;
    if (bus.clear) begin
      fill_cnt_d = CNT_ZERO;
      state_d    = ST_IDLE;
    end
`ifdef SR_TAPS_TRAIL_PAD_EN
    else if (state_q == ST_DRAIN) begin
      // Drain is entered only from FILL/FULL, so fill_cnt_q is at least 1 here.
      shift_s    = 1'b1;
      pad_s      = 1'b1;
      fill_cnt_d = fill_cnt_q - CNT_ONE;
      if (fill_cnt_d == CNT_ZERO) begin
        drain_done_d = 1'b1;
        state_d      = ST_IDLE;
      end else begin
        window_valid_d = 1'b1;
      end
    end else if (bus.drain) begin
      // The cycle the request is sampled never shifts, even with shift_in high.
      if (state_q == ST_IDLE) begin
        drain_done_d = 1'b1;
      end else begin
        state_d = ST_DRAIN;
      end
    end
`endif
    else if (accept_s) begin
      shift_s = 1'b1;
      if (fill_cnt_q == CNT_FULL) begin
        fill_cnt_d = fill_cnt_q;
      end else begin
        fill_cnt_d = fill_cnt_q + CNT_ONE;
      end
      if (fill_cnt_d == CNT_FULL) begin
        window_valid_d = 1'b1;
        state_d        = ST_FULL;
      end else begin
        state_d = ST_FILL;
      end
    end else begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
    end
  end

  assign tap_en_s = bus.clear | shift_s;

  // Load values for the tap chain: zeros on clear, otherwise the shifted neighbour.
  always_comb begin
    if (bus.clear) begin
      tap_ld_s[0] = {WIDTH{1'b0}};
    end else if (pad_s) begin
      tap_ld_s[0] = {WIDTH{1'b0}};
    end else begin
      tap_ld_s[0] = bus.inp_sr;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (bus.clear) begin
        tap_ld_s[k] = {WIDTH{1'b0}};
      end else begin
        tap_ld_s[k] = tap_val_s[k-1];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_tap
      sr_tap_stage #(
        .WIDTH (WIDTH)
      ) u_tap (
        .clk      (clk),
        .rst      (rst),
        .en       (tap_en_s),
        .load_val (tap_ld_s[g]),
        .q        (tap_val_s[g])
      );
      assign bus.taps[tap_lsb(g, WIDTH) +: WIDTH] = tap_val_s[g];
    end
  endgenerate

  // FSM state, fill counter and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      fill_cnt_q     <= CNT_ZERO;
      window_valid_q <= 1'b0;
      drain_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_cnt_q     <= fill_cnt_d;
      window_valid_q <= window_valid_d;
      drain_done_q   <= drain_done_d;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.fill_cnt     = fill_cnt_q;
  assign bus.window_valid = window_valid_q;
  assign bus.drain_done   = drain_done_q;

endmodule

// File: tb/tb_shift_register_taps.sv
// Directed self-checking bench for shift_register_taps (WIDTH=16, DEPTH=3).
// Drain/clear-mid-drain vectors run when SR_TAPS_TRAIL_PAD_EN is defined;
// the drain-ignored vectors run otherwise.
module tb_shift_register_taps;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  shift_register_taps_if #(.WIDTH(16), .DEPTH(3)) bus ();

  shift_register_taps #(
    .WIDTH (16),
    .DEPTH (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [47:0] taps, input logic [1:0] cnt,
                             input logic wv, input logic dd, input logic rdy);
    check_val({tag, "_taps"}, 64'(bus.taps), 64'(taps));
    check_val({tag, "_cnt"},  64'(bus.fill_cnt), 64'(cnt));
    check_val({tag, "_wv"},   64'(bus.window_valid), 64'(wv));
    check_val({tag, "_dd"},   64'(bus.drain_done), 64'(dd));
    check_val({tag, "_rdy"},  64'(bus.in_ready), 64'(rdy));
  endtask

  task automatic push(input logic [15:0] v);
    bus.shift_in = 1'b1;
    bus.inp_sr   = v;
    step();
    bus.shift_in = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    bus.clear    = 1'b0;
    bus.shift_in = 1'b0;
    bus.inp_sr   = 16'h0000;
    bus.drain    = 1'b0;
    #12;
    check_state("reset", 48'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // Fill: window_valid only once the third sample lands.
    push(16'h0011);
    check_state("fill1", {16'h0000, 16'h0000, 16'h0011}, 2'd1, 1'b0, 1'b0, 1'b1);
    push(16'h0022);
    check_state("fill2", {16'h0000, 16'h0011, 16'h0022}, 2'd2, 1'b0, 1'b0, 1'b1);
    push(16'h0033);
    check_state("fill3", {16'h0011, 16'h0022, 16'h0033}, 2'd3, 1'b1, 1'b0, 1'b1);

    // Idle cycle holds everything and emits no pulse.
    bus.inp_sr = 16'h00EE;
    step();
    check_state("idle", {16'h0011, 16'h0022, 16'h0033}, 2'd3, 1'b0, 1'b0, 1'b1);

    // Steady state: oldest sample drops off.
    push(16'h0044);
    check_state("steady", {16'h0022, 16'h0033, 16'h0044}, 2'd3, 1'b1, 1'b0, 1'b1);

`ifdef SR_TAPS_TRAIL_PAD_EN
    // Drain from full with shift_in held high: nothing is accepted.
    bus.drain    = 1'b1;
    bus.shift_in = 1'b1;
    bus.inp_sr   = 16'h0099;
    step();
    bus.drain = 1'b0;
    check_state("drn_req", {16'h0022, 16'h0033, 16'h0044}, 2'd3, 1'b0, 1'b0, 1'b0);
    step();
    check_state("drn1", {16'h0033, 16'h0044, 16'h0000}, 2'd2, 1'b1, 1'b0, 1'b0);
    step();
    check_state("drn2", {16'h0044, 16'h0000, 16'h0000}, 2'd1, 1'b1, 1'b0, 1'b0);
    step();
    check_state("drn3", 48'h0, 2'd0, 1'b0, 1'b1, 1'b1);
    bus.shift_in = 1'b0;
    step();
    check_state("drn_idle", 48'h0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Clear mid-drain with a competing shift: 0x55 must not load.
    push(16'h00A1);
    push(16'h00A2);
    push(16'h00A3);
    bus.drain = 1'b1;
    step();
    bus.drain = 1'b0;
    step();
    check_state("pre_clr", {16'h00A2, 16'h00A3, 16'h0000}, 2'd2, 1'b1, 1'b0, 1'b0);
    bus.clear    = 1'b1;
    bus.shift_in = 1'b1;
    bus.inp_sr   = 16'h0055;
    step();
    bus.clear    = 1'b0;
    bus.shift_in = 1'b0;
    check_state("clr", 48'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    step();
    check_state("clr_hold", 48'h0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Drain while IDLE: drain_done next cycle, no shift.
    bus.drain = 1'b1;
    step();
    bus.drain = 1'b0;
    check_state("drn_empty", 48'h0, 2'd0, 1'b0, 1'b1, 1'b1);
    push(16'h0011);
    push(16'h0022);
    push(16'h0033);
`else
    // Drain ignored: the shift in the same cycle proceeds normally.
    bus.drain    = 1'b1;
    bus.shift_in = 1'b1;
    bus.inp_sr   = 16'h0066;
    step();
    bus.drain    = 1'b0;
    bus.shift_in = 1'b0;
    check_state("nodrn", {16'h0033, 16'h0044, 16'h0066}, 2'd3, 1'b1, 1'b0, 1'b1);
    step();
    check_state("nodrn_hold", {16'h0033, 16'h0044, 16'h0066}, 2'd3, 1'b0, 1'b0, 1'b1);
    push(16'h0077);
    check_state("nodrn_shift", {16'h0044, 16'h0066, 16'h0077}, 2'd3, 1'b1, 1'b0, 1'b1);
`endif

    // Async reset between edges while FULL.
    push(16'h00B0);
    check_val("full_before_rst", 64'(bus.fill_cnt), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 48'h0, 2'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    push(16'h0077);
    check_state("post_rst", {16'h0000, 16'h0000, 16'h0077}, 2'd1, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
